// File: rtl/am29_phase_pkg.sv
// Shared types and constants for the timing-phase sequencer.
package am29_phase_pkg;

    localparam int unsigned PHASE_W = 3;
    localparam logic [PHASE_W-1:0] PHASE_ONE = PHASE_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        STALL = 2'd2
    } state_t;

endpackage

// File: rtl/phase_sequencer_counter.sv
// Phase counter: load-zero, increment or hold, with terminal compare against
// the latched last-phase index.
module phase_counter
    import am29_phase_pkg::*;
(
    input  logic               clk,
    input  logic               rst_,
    input  logic               load_zero,
    input  logic               inc,
    input  logic [PHASE_W-1:0] len_q,
    output logic [PHASE_W-1:0] phase,
    output logic               at_end
);

    // Phase register; load-zero has priority over increment.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            phase <= '0;
        end else if (load_zero) begin
            phase <= '0;
        end else if (inc) begin
            phase <= phase + PHASE_ONE;
        end
    end

    assign at_end = (phase == len_q);

endmodule

// File: rtl/phase_sequencer.sv
// Timing-phase sequencer driving the select/enable pins of a 3-to-8 decoder.
// Steps T0..Tlen per machine cycle with start/stop/single-step control and
// ready-driven wait-state insertion.
module phase_sequencer
    import am29_phase_pkg::*;
#(
    parameter logic [PHASE_W-1:0] RESET_LEN      = 3'd7,
    parameter bit                 WAIT_EN        = 1'b1,
    parameter bit                 BLANK_ON_STALL = 1'b0
) (
    input  logic               clk,
    input  logic               rst_,
    input  logic               clr,
    input  logic               start,
    input  logic               step,
    input  logic               stop,
    input  logic               ready,
    input  logic [PHASE_W-1:0] len,
    input  logic [PHASE_W-1:0] wait_phase,
    input  logic               oe_,
    output logic               sel_a,
    output logic               sel_b,
    output logic               sel_c,
    output logic               g1,
    output logic               g2a_,
    output logic               g2b_,
    output logic [PHASE_W-1:0] phase,
    output logic               busy,
    output logic               stalled,
    output logic               cycle_end
);

    state_t             state_q;
    state_t             state_d;
    logic [PHASE_W-1:0] len_q;
    logic               stop_pend_q;
    logic               step_mode_q;

    logic               at_end;
    logic               stall_cond;
    logic               advance;
    logic               wrap;
    logic               finish;
    logic               go;
    logic               cnt_zero;
    logic               cnt_inc;

    // Datapath control: when the phase advances, wraps, or the cycle ends.
    always_comb begin
        stall_cond = WAIT_EN && (phase == wait_phase) && !ready;
        advance    = 1'b0;
        if (state_q == RUN) begin
            advance = !stall_cond;
        end else if (state_q == STALL) begin
            advance = ready;
        end
        wrap     = advance && at_end;
        finish   = wrap && (stop_pend_q || step_mode_q || stop);
        go       = (state_q == IDLE) && (start || step);
        cnt_zero = clr || go || wrap;
        cnt_inc  = advance && !at_end;
    end

    // Next-state logic; clr overrides everything except reset.
    always_comb begin
        state_d = state_q;
        if (clr) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (go) begin
                        state_d = RUN;
                    end
                end
                RUN, STALL: begin
                    if (advance) begin
                        state_d = finish ? IDLE : RUN;
                    end else begin
                        state_d = STALL;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Cycle length latch and stop/step flags; len_q survives clr.
    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            len_q       <= RESET_LEN;
            stop_pend_q <= 1'b0;
            step_mode_q <= 1'b0;
        end else if (clr) begin
            stop_pend_q <= 1'b0;
            step_mode_q <= 1'b0;
        end else if (go) begin
            len_q       <= len;
            stop_pend_q <= 1'b0;
            step_mode_q <= !start;
        end else if (state_q != IDLE) begin
            if (finish) begin
                stop_pend_q <= 1'b0;
                step_mode_q <= 1'b0;
            end else begin
                if (wrap) begin
                    len_q <= len;
                end
                if (stop) begin
                    stop_pend_q <= 1'b1;
                end
            end
        end
    end

    phase_counter u_phase_counter (
        .clk       (clk),
        .rst_      (rst_),
        .load_zero (cnt_zero),
        .inc       (cnt_inc),
        .len_q     (len_q),
        .phase     (phase),
        .at_end    (at_end)
    );

    assign busy      = (state_q != IDLE);
    assign stalled   = (state_q == STALL);
    assign cycle_end = wrap && !clr;
    assign sel_a     = phase[0];
    assign sel_b     = phase[1];
    assign sel_c     = phase[2];
    assign g1        = busy;
    assign g2a_      = !(busy && !(BLANK_ON_STALL && stalled));
    assign g2b_      = oe_;

endmodule

// File: tb/tb_phase_sequencer.sv
// Self-checking bench for phase_sequencer: stimulus tables per scenario,
// expected outputs queued at drive time and compared at the falling edge.
module tb_phase_sequencer;

    logic       clk = 1'b0;
    logic       rst_;
    logic       clr, start, step, stop, ready, oe_;
    logic [2:0] len, wait_phase;

    logic       sel_a, sel_b, sel_c, g1, g2a_, g2b_, busy, stalled, cycle_end;
    logic [2:0] phase;
    logic       nw_sel_a, nw_sel_b, nw_sel_c, nw_g1, nw_g2a_, nw_g2b_;
    logic       nw_busy, nw_stalled, nw_cycle_end;
    logic [2:0] nw_phase;

    int passed = 0;
    int total  = 0;

    // ctl = {clr, start, step, stop, ready}; flg = expected {busy, stalled, cycle_end}
    typedef struct packed {
        logic [4:0] ctl;
        logic [2:0] len;
        logic [2:0] wp;
        logic [2:0] flg;
        logic [2:0] ph;
    } stim_t;

    typedef struct packed {
        logic [2:0] flg;
        logic [2:0] ph;
        logic       oe;
    } exp_t;

    stim_t      stim[$];
    exp_t       sb[$];
    logic [5:0] sb_nw[$];

    always #5 clk = ~clk;

    phase_sequencer #(.RESET_LEN(3'd7), .WAIT_EN(1'b1), .BLANK_ON_STALL(1'b0)) dut (
        .clk(clk), .rst_(rst_), .clr(clr), .start(start), .step(step), .stop(stop),
        .ready(ready), .len(len), .wait_phase(wait_phase), .oe_(oe_),
        .sel_a(sel_a), .sel_b(sel_b), .sel_c(sel_c), .g1(g1), .g2a_(g2a_), .g2b_(g2b_),
        .phase(phase), .busy(busy), .stalled(stalled), .cycle_end(cycle_end)
    );

    phase_sequencer #(.RESET_LEN(3'd7), .WAIT_EN(1'b0), .BLANK_ON_STALL(1'b0)) dut_nw (
        .clk(clk), .rst_(rst_), .clr(clr), .start(start), .step(step), .stop(stop),
        .ready(ready), .len(len), .wait_phase(wait_phase), .oe_(oe_),
        .sel_a(nw_sel_a), .sel_b(nw_sel_b), .sel_c(nw_sel_c), .g1(nw_g1), .g2a_(nw_g2a_),
        .g2b_(nw_g2b_), .phase(nw_phase), .busy(nw_busy), .stalled(nw_stalled),
        .cycle_end(nw_cycle_end)
    );

    function automatic stim_t s(input logic [4:0] c, input logic [2:0] l, input logic [2:0] w,
                                input logic [2:0] f, input logic [2:0] p);
        stim_t r;
        r.ctl = c; r.len = l; r.wp = w; r.flg = f; r.ph = p;
        return r;
    endfunction

    // Drive one cycle of inputs and queue the outputs they should produce.
    task automatic apply(input stim_t r);
        exp_t e;
        {clr, start, step, stop, ready} = r.ctl;
        len        = r.len;
        wait_phase = r.wp;
        oe_        = 1'($urandom_range(0, 1));
        e.flg = r.flg; e.ph = r.ph; e.oe = oe_;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        rst_ = 1'b0;
        {clr, start, step, stop} = '0;
        ready = 1'b1; len = 3'd7; wait_phase = 3'd7; oe_ = 1'b1;
        #1;
        total++;
        if ({phase, sel_c, sel_b, sel_a, g1, g2a_, busy, stalled, cycle_end} !== 11'b000_000_0_1_000)
            $display("FAIL reset_state phase=%0d g1=%b g2a_=%b busy=%b stalled=%b ce=%b", phase, g1, g2a_, busy, stalled, cycle_end);
        else passed++;
        @(posedge clk); #1;
        rst_ = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        total++;
        if (phase !== 3'd5 || busy !== 1'b1)
            $display("FAIL reset_pre_phase phase=%0d busy=%b want phase=5 busy=1", phase, busy);
        else passed++;
        #2 rst_ = 1'b0;
        #1;
        total++;
        if (phase !== 3'd0 || g1 !== 1'b0 || g2a_ !== 1'b1 || busy !== 1'b0)
            $display("FAIL reset_async phase=%0d g1=%b g2a_=%b busy=%b want 0/0/1/0", phase, g1, g2a_, busy);
        else passed++;
        @(posedge clk); #1;
        rst_ = 1'b1;
    endtask

    task automatic test_free_run;
        exp_t e; logic [12:0] got, want;
        stim.push_back(s(5'b01001, 3, 7, 3'b000, 0));
        stim.push_back(s(5'b00001, 5, 7, 3'b100, 0));
        stim.push_back(s(5'b00001, 5, 7, 3'b100, 1));
        stim.push_back(s(5'b00001, 5, 7, 3'b100, 2));
        stim.push_back(s(5'b00001, 3, 7, 3'b101, 3));
        stim.push_back(s(5'b00011, 3, 7, 3'b100, 0));
        stim.push_back(s(5'b00001, 3, 7, 3'b100, 1));
        stim.push_back(s(5'b00001, 3, 7, 3'b100, 2));
        stim.push_back(s(5'b00001, 3, 7, 3'b101, 3));
        stim.push_back(s(5'b00001, 3, 7, 3'b000, 0));
        for (int i = 0; stim.size() > 0; i++) begin
            apply(stim.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            got  = {busy, stalled, cycle_end, phase, sel_c, sel_b, sel_a, g1, g2a_, g2b_};
            want = {e.flg, e.ph, e.ph, e.flg[2], ~e.flg[2], e.oe};
            total++;
            if (got !== want) $display("FAIL free_run cyc%0d got=%b want=%b", i, got, want);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_stop;
        exp_t e; logic [12:0] got, want;
        for (int r = 0; r < 2; r++) begin
            stim.push_back(s(5'b01001, 7, 7, 3'b000, 0));
            stim.push_back(s(5'b00001, 7, 7, 3'b100, 0));
            stim.push_back(s(5'b00011, 7, 7, 3'b100, 1));
            for (int p = 2; p < 7; p++) stim.push_back(s(5'b00001, 7, 7, 3'b100, 3'(p)));
            stim.push_back(s(5'b00001, 7, 7, 3'b101, 7));
        end
        stim.push_back(s(5'b00001, 7, 7, 3'b000, 0));
        for (int i = 0; stim.size() > 0; i++) begin
            apply(stim.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            got  = {busy, stalled, cycle_end, phase, sel_c, sel_b, sel_a, g1, g2a_, g2b_};
            want = {e.flg, e.ph, e.ph, e.flg[2], ~e.flg[2], e.oe};
            total++;
            if (got !== want) $display("FAIL stop cyc%0d got=%b want=%b", i, got, want);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wait;
        exp_t e; logic [12:0] got, want; logic [5:0] gnw, wnw;
        stim.push_back(s(5'b01001, 7, 2, 3'b000, 0));
        stim.push_back(s(5'b00001, 7, 2, 3'b100, 0));
        stim.push_back(s(5'b00001, 7, 2, 3'b100, 1));
        stim.push_back(s(5'b00000, 7, 2, 3'b100, 2));
        stim.push_back(s(5'b00000, 7, 2, 3'b110, 2));
        stim.push_back(s(5'b00000, 7, 2, 3'b110, 2));
        stim.push_back(s(5'b00001, 7, 2, 3'b110, 2));
        stim.push_back(s(5'b00011, 7, 2, 3'b100, 3));
        stim.push_back(s(5'b00001, 7, 2, 3'b100, 4));
        stim.push_back(s(5'b00001, 7, 2, 3'b100, 5));
        stim.push_back(s(5'b00001, 7, 2, 3'b100, 6));
        stim.push_back(s(5'b00001, 7, 2, 3'b101, 7));
        stim.push_back(s(5'b00001, 7, 2, 3'b000, 0));
        sb_nw.push_back(6'b000_000);
        for (int p = 0; p < 7; p++) sb_nw.push_back({3'b100, 3'(p)});
        sb_nw.push_back(6'b101_111);
        repeat (4) sb_nw.push_back(6'b000_000);
        for (int i = 0; stim.size() > 0; i++) begin
            apply(stim.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            got  = {busy, stalled, cycle_end, phase, sel_c, sel_b, sel_a, g1, g2a_, g2b_};
            want = {e.flg, e.ph, e.ph, e.flg[2], ~e.flg[2], e.oe};
            total++;
            if (got !== want) $display("FAIL wait cyc%0d got=%b want=%b", i, got, want);
            else passed++;
            gnw = {nw_busy, nw_stalled, nw_cycle_end, nw_phase};
            wnw = sb_nw.pop_front();
            total++;
            if (gnw !== wnw) $display("FAIL wait_disabled cyc%0d got=%b want=%b", i, gnw, wnw);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_step;
        exp_t e; logic [12:0] got, want;
        stim.push_back(s(5'b00101, 2, 7, 3'b000, 0));
        stim.push_back(s(5'b00001, 2, 7, 3'b100, 0));
        stim.push_back(s(5'b00001, 2, 7, 3'b100, 1));
        stim.push_back(s(5'b00001, 2, 7, 3'b101, 2));
        stim.push_back(s(5'b00001, 2, 7, 3'b000, 0));
        stim.push_back(s(5'b00001, 2, 7, 3'b000, 0));
        stim.push_back(s(5'b01101, 1, 7, 3'b000, 0));
        stim.push_back(s(5'b00001, 1, 7, 3'b100, 0));
        stim.push_back(s(5'b00001, 1, 7, 3'b101, 1));
        stim.push_back(s(5'b00001, 1, 7, 3'b100, 0));
        stim.push_back(s(5'b00011, 1, 7, 3'b101, 1));
        stim.push_back(s(5'b00001, 1, 7, 3'b000, 0));
        for (int i = 0; stim.size() > 0; i++) begin
            apply(stim.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            got  = {busy, stalled, cycle_end, phase, sel_c, sel_b, sel_a, g1, g2a_, g2b_};
            want = {e.flg, e.ph, e.ph, e.flg[2], ~e.flg[2], e.oe};
            total++;
            if (got !== want) $display("FAIL step cyc%0d got=%b want=%b", i, got, want);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_corners;
        exp_t e; logic [12:0] got, want;
        // len = 0: phase pinned at 0, cycle_end on every advancing clock
        stim.push_back(s(5'b01001, 0, 7, 3'b000, 0));
        stim.push_back(s(5'b00001, 0, 7, 3'b101, 0));
        stim.push_back(s(5'b00001, 0, 7, 3'b101, 0));
        stim.push_back(s(5'b00011, 0, 7, 3'b101, 0));
        stim.push_back(s(5'b00001, 0, 7, 3'b000, 0));
        // stall on the last phase withholds the wrap
        stim.push_back(s(5'b01001, 4, 4, 3'b000, 0));
        for (int p = 0; p < 4; p++) stim.push_back(s(5'b00001, 4, 4, 3'b100, 3'(p)));
        stim.push_back(s(5'b00000, 4, 4, 3'b100, 4));
        stim.push_back(s(5'b00000, 4, 4, 3'b110, 4));
        stim.push_back(s(5'b00011, 4, 4, 3'b111, 4));
        stim.push_back(s(5'b00001, 4, 4, 3'b000, 0));
        // clr mid-stall drops pending stop too
        stim.push_back(s(5'b01001, 7, 2, 3'b000, 0));
        stim.push_back(s(5'b00001, 7, 2, 3'b100, 0));
        stim.push_back(s(5'b00001, 7, 2, 3'b100, 1));
        stim.push_back(s(5'b00010, 7, 2, 3'b100, 2));
        stim.push_back(s(5'b10000, 7, 2, 3'b110, 2));
        stim.push_back(s(5'b01001, 1, 7, 3'b000, 0));
        stim.push_back(s(5'b00001, 1, 7, 3'b100, 0));
        stim.push_back(s(5'b00001, 1, 7, 3'b101, 1));
        stim.push_back(s(5'b00001, 1, 7, 3'b100, 0));
        stim.push_back(s(5'b00011, 1, 7, 3'b101, 1));
        stim.push_back(s(5'b00001, 1, 7, 3'b000, 0));
        for (int i = 0; stim.size() > 0; i++) begin
            apply(stim.pop_front());
            @(negedge clk);
            e = sb.pop_front();
            got  = {busy, stalled, cycle_end, phase, sel_c, sel_b, sel_a, g1, g2a_, g2b_};
            want = {e.flg, e.ph, e.ph, e.flg[2], ~e.flg[2], e.oe};
            total++;
            if (got !== want) $display("FAIL corners cyc%0d got=%b want=%b", i, got, want);
            else passed++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL timeout passed=%0d total=%0d", passed, total);
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_free_run();
        test_stop();
        test_wait();
        test_step();
        test_corners();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
